// File: rtl/cr_clic_pkg.sv
// Shared encodings and sizing helpers for the CLIC sequential priority arbiter.
package cr_clic_pkg;

  localparam int INT_NUM_DEF = 64;
  localparam int GRP_NUM_DEF = 8;
  localparam int GRP_CNT_NUM = INT_NUM_DEF / GRP_NUM_DEF;

  // Width of a counter/index over n items, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int GRP_CNT_W = cnt_w(GRP_CNT_NUM);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } arb_st_e;

endpackage

// File: rtl/cr_clic_arb_grp.sv
// Combinational GRP_NUM-way max-finder over candidates (pending & enable & prio > thresh).
// Strict > while walking upward means the lowest index keeps a tie.
module cr_clic_arb_grp
  import cr_clic_pkg::*;
#(
  parameter int GRP_NUM    = GRP_NUM_DEF,
  parameter int PRIO_WIDTH = 8,
  parameter int IDX_W      = cnt_w(GRP_NUM)
)(
  input  logic [GRP_NUM-1:0]                 pend_i,
  input  logic [GRP_NUM-1:0]                 en_i,
  input  logic [GRP_NUM-1:0][PRIO_WIDTH-1:0] prio_i,
  input  logic [PRIO_WIDTH-1:0]              thresh_i,
  output logic                               grp_vld_o,
  output logic [IDX_W-1:0]                   grp_idx_o,
  output logic [PRIO_WIDTH-1:0]              grp_prio_o
);

  always_comb begin
    grp_vld_o  = 1'b0;
    grp_idx_o  = '0;
    grp_prio_o = '0;
    for (int i = 0; i < GRP_NUM; i++) begin
      if (pend_i[i] && en_i[i] && (prio_i[i] > thresh_i) &&
          (!grp_vld_o || (prio_i[i] > grp_prio_o))) begin
        grp_vld_o  = 1'b1;
        grp_idx_o  = IDX_W'(i);
        grp_prio_o = prio_i[i];
      end
    end
  end

endmodule

// File: rtl/cr_clic_arb.sv
// CLIC sequential priority arbiter: scans GRP_NUM sources per cycle, presents winner via vld/ack.
// Optional macro CR_CLIC_ARB_RESCAN_EN: background scan in HOLD can upgrade to a higher-priority winner.
module cr_clic_arb
  import cr_clic_pkg::*;
#(
  parameter int INT_NUM    = INT_NUM_DEF,
  parameter int GRP_NUM    = GRP_NUM_DEF,
  parameter int PRIO_WIDTH = 8,
  parameter int ID_WIDTH   = 6
)(
  input  logic                          clic_clk,
  input  logic                          cpurst_b,
  input  logic [INT_NUM-1:0]            int_pending,
  input  logic [INT_NUM-1:0]            int_enable,
  input  logic [PRIO_WIDTH*INT_NUM-1:0] int_prio,
  input  logic [PRIO_WIDTH-1:0]         core_thresh,
  input  logic                          arb_ack,
  output logic                          arb_vld,
  output logic [INT_NUM-1:0]            arb_sel_onehot,
  output logic [ID_WIDTH-1:0]           arb_id,
  output logic [PRIO_WIDTH-1:0]         arb_prio
);

  localparam int NGRP = INT_NUM / GRP_NUM;
  localparam int CW   = cnt_w(NGRP);
  localparam int LW   = cnt_w(GRP_NUM);
  localparam logic [CW-1:0] LAST = CW'(NGRP - 1);

  arb_st_e                 st_q;
  logic [CW-1:0]           grp_cnt_q;
  logic                    best_vld_q, arb_vld_q;
  logic [ID_WIDTH-1:0]     best_id_q, arb_id_q;
  logic [PRIO_WIDTH-1:0]   best_prio_q, arb_prio_q;

  logic [NGRP-1:0][GRP_NUM-1:0]                 pend_g, en_g;
  logic [NGRP-1:0][GRP_NUM-1:0][PRIO_WIDTH-1:0] prio_g;
  logic [INT_NUM-1:0][PRIO_WIDTH-1:0]           prio_a;

  assign pend_g = int_pending;
  assign en_g   = int_enable;
  assign prio_g = int_prio;
  assign prio_a = int_prio;

  logic                  grp_vld;
  logic [LW-1:0]         grp_idx;
  logic [PRIO_WIDTH-1:0] grp_prio;
  logic [ID_WIDTH-1:0]   grp_id;

  cr_clic_arb_grp #(
    .GRP_NUM   (GRP_NUM),
    .PRIO_WIDTH(PRIO_WIDTH),
    .IDX_W     (LW)
  ) u_grp (
    .pend_i    (pend_g[grp_cnt_q]),
    .en_i      (en_g[grp_cnt_q]),
    .prio_i    (prio_g[grp_cnt_q]),
    .thresh_i  (core_thresh),
    .grp_vld_o (grp_vld),
    .grp_idx_o (grp_idx),
    .grp_prio_o(grp_prio)
  );

  assign grp_id = ID_WIDTH'(grp_cnt_q) * ID_WIDTH'(GRP_NUM) + ID_WIDTH'(grp_idx);

  // Running best merged with this cycle's group; strict > keeps the earlier group on ties.
  logic                  take, fin_vld, win_ok;
  logic [ID_WIDTH-1:0]   fin_id;
  logic [PRIO_WIDTH-1:0] fin_prio;

  assign take     = grp_vld && (!best_vld_q || (grp_prio > best_prio_q));
  assign fin_vld  = best_vld_q | grp_vld;
  assign fin_id   = take ? grp_id : best_id_q;
  assign fin_prio = take ? grp_prio : best_prio_q;
  assign win_ok   = int_pending[arb_id_q] & int_enable[arb_id_q] &
                    (prio_a[arb_id_q] > core_thresh);

  always_ff @(posedge clic_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      st_q        <= IDLE;
      grp_cnt_q   <= '0;
      best_vld_q  <= 1'b0;
      best_id_q   <= '0;
      best_prio_q <= '0;
      arb_vld_q   <= 1'b0;
      arb_id_q    <= '0;
      arb_prio_q  <= '0;
    end else begin
      case (st_q)
        IDLE: begin
          if (|(int_pending & int_enable)) begin
            st_q       <= SCAN;
            best_vld_q <= 1'b0;
            grp_cnt_q  <= '0;
          end
        end
        SCAN: begin
          best_vld_q  <= fin_vld;
          best_id_q   <= fin_id;
          best_prio_q <= fin_prio;
          if (grp_cnt_q == LAST) begin
            grp_cnt_q <= '0;
            if (fin_vld) begin
              st_q       <= HOLD;
              arb_vld_q  <= 1'b1;
              arb_id_q   <= fin_id;
              arb_prio_q <= fin_prio;
            end else begin
              st_q <= IDLE;
            end
          end else begin
            grp_cnt_q <= grp_cnt_q + CW'(1);
          end
        end
        HOLD: begin
          // Ack outranks withdrawal and any background upgrade.
          if (arb_ack || !win_ok) begin
            st_q       <= IDLE;
            arb_vld_q  <= 1'b0;
            arb_id_q   <= '0;
            arb_prio_q <= '0;
          end
`ifdef CR_CLIC_ARB_RESCAN_EN
          else if (grp_vld && (grp_prio > arb_prio_q)) begin
            arb_id_q   <= grp_id;
            arb_prio_q <= grp_prio;
          end
          grp_cnt_q <= (grp_cnt_q == LAST) ? '0 : grp_cnt_q + CW'(1);
`endif
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign arb_vld        = arb_vld_q;
  assign arb_id         = arb_id_q;
  assign arb_prio       = arb_prio_q;
  assign arb_sel_onehot = arb_vld_q ? (INT_NUM'(1) << arb_id_q) : '0;

endmodule
